// File: rtl/sccb_config_sequencer_if.sv
// Write-request bus between the configuration sequencer (master) and the SCCB byte master (slave).
interface sccb_config_sequencer_if;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       wr_done;
  logic       wr_nack;

  modport master (
    output wr_req, wr_addr, wr_data,
    input  wr_ready, wr_done, wr_nack
  );

  modport slave (
    input  wr_req, wr_addr, wr_data,
    output wr_ready, wr_done, wr_nack
  );
endinterface

// File: rtl/sccb_config_sequencer.sv
// Walks a camera register table after power-up and pushes each entry to an SCCB byte master.
// Optional macro SCCB_RETRY_EN: re-issue a NACKed entry up to MAX_RETRY times before aborting.
module sccb_config_sequencer #(
  parameter int unsigned TABLE_DEPTH     = 128,
  parameter int unsigned TABLE_AW        = $clog2(TABLE_DEPTH),
  parameter int unsigned PWR_WAIT_CYCLES = 1_000_000,
  parameter int unsigned DLY_CYCLES      = 1_000_000,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [TABLE_AW-1:0]     tbl_addr,
  input  logic [15:0]             tbl_data,
  sccb_config_sequencer_if.master wr,
  output logic                    busy,
  output logic                    cfg_done,
  output logic                    cfg_err,
  output logic [TABLE_AW-1:0]     err_index
);

  localparam int unsigned CNT_MAX = (PWR_WAIT_CYCLES > DLY_CYCLES) ? PWR_WAIT_CYCLES : DLY_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  // One extra index bit so that reaching TABLE_DEPTH is representable.
  localparam int unsigned IDX_W   = TABLE_AW + 1;
  localparam int unsigned RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [15:0] ENTRY_END = 16'hFFFF;
  localparam logic [15:0] ENTRY_DLY = 16'hFFF0;

`ifdef SCCB_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE,
    PWR_WAIT,
    FETCH,
    DECODE,
    ISSUE,
    WAIT_DONE,
    DELAY,
    DONE,
    ERROR
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RTY_W-1:0]    rty_q, rty_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic [TABLE_AW-1:0] err_idx_q, err_idx_d;
  logic                tbl_end;

  assign tbl_end = (idx_q >= IDX_W'(TABLE_DEPTH)) || (tbl_data == ENTRY_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= PWR_WAIT;
      idx_q     <= '0;
      cnt_q     <= '0;
      rty_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rty_q     <= rty_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      err_idx_q <= err_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rty_d     = rty_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_idx_d = err_idx_q;

    // Start wins over every state; an in-flight transaction's wr_done is simply never looked at.
    if (start) begin
      state_d   = FETCH;
      idx_d     = '0;
      cnt_d     = '0;
      rty_d     = '0;
      err_idx_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        PWR_WAIT: begin
          if (cnt_q == CNT_W'(PWR_WAIT_CYCLES - 1)) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = FETCH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        FETCH: state_d = DECODE;
        DECODE: begin
          if (tbl_end) begin
            state_d = DONE;
          end else if (tbl_data == ENTRY_DLY) begin
            cnt_d   = '0;
            state_d = DELAY;
          end else begin
            addr_d  = tbl_data[15:8];
            data_d  = tbl_data[7:0];
            rty_d   = '0;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (wr.wr_ready) state_d = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (wr.wr_done) begin
            if (!wr.wr_nack) begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = FETCH;
            end else if (RETRY_EN && (rty_q < RTY_W'(MAX_RETRY))) begin
              rty_d   = rty_q + RTY_W'(1);
              state_d = ISSUE;
            end else begin
              err_idx_d = idx_q[TABLE_AW-1:0];
              state_d   = ERROR;
            end
          end
        end
        DELAY: begin
          if (cnt_q == CNT_W'(DLY_CYCLES - 1)) begin
            cnt_d   = '0;
            idx_d   = idx_q + IDX_W'(1);
            state_d = FETCH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_d = DONE;
        ERROR:   state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

  // Request is gated by ready so it is high only in the single handshake cycle.
  assign wr.wr_req  = (state_q == ISSUE) && wr.wr_ready && !start;
  assign wr.wr_addr = addr_q;
  assign wr.wr_data = data_q;

  assign tbl_addr  = idx_q[TABLE_AW-1:0];
  assign busy      = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
  assign cfg_done  = (state_q == DONE);
  assign cfg_err   = (state_q == ERROR);
  assign err_index = err_idx_q;

endmodule
